// File: rtl/y86_mem_responder_pkg.sv
// y86_mem_responder_pkg: shared bus widths, FSM state encodings and the address range check
//   `ADDR_BUS / `DATA_BUS : bus widths used by every file of the responder
//   `ST_IDLE / `ST_WAIT / `ST_RESP : FSM encodings
`ifndef Y86_DEFINE
`define Y86_DEFINE
`define ADDR_BUS 64
`define DATA_BUS 64
`define ST_IDLE 2'd0
`define ST_WAIT 2'd1
`define ST_RESP 2'd2
`endif

package y86_mem_responder_pkg;
    typedef logic [`ADDR_BUS-1:0] addr_t;
    typedef logic [`DATA_BUS-1:0] data_t;
    typedef logic [3:0] cnt_t;
    typedef enum logic [1:0] {IDLE = `ST_IDLE, WAIT = `ST_WAIT, RESP = `ST_RESP} state_t;
    localparam int WORD_BYTES = `DATA_BUS / 8;
    // Unsigned full-width compare so addresses near 2^64 never wrap into range.
    function automatic logic out_of_range(input addr_t addr, input addr_t depth);
        return addr > depth - addr_t'(WORD_BYTES);
    endfunction
endpackage

// File: rtl/y86_mem_responder_mem_byte_array.sv
// mem_byte_array: byte-wide storage with an 8-byte little-endian read port and write port
//   clk_i : clock
//   addr  : byte address of the 8-byte word (may be unaligned)
//   we    : write all 8 bytes of wdata at the rising edge
//   wdata : store data, byte addr at [7:0]
//   rdata : combinational load data, byte addr at [7:0]
module mem_byte_array
    import y86_mem_responder_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024
) (
    input  logic                           clk_i,
    input  logic [$clog2(DEPTH_BYTES)-1:0] addr,
    input  logic                           we,
    input  data_t                          wdata,
    output data_t                          rdata
);
    localparam int AW = $clog2(DEPTH_BYTES);
    logic [7:0] mem [DEPTH_BYTES];
    always_comb
        for (int i = 0; i < WORD_BYTES; i++)
            rdata[8*i +: 8] = mem[addr + AW'(i)];
    // No reset: contents survive rst_i.
    always_ff @(posedge clk_i)
        if (we)
            for (int i = 0; i < WORD_BYTES; i++)
                mem[addr + AW'(i)] <= wdata[8*i +: 8];
endmodule

// File: rtl/y86_mem_responder.sv
// y86_mem_responder: valid/ready 64-bit load/store responder with fixed wait latency
//   clk_i, rst_i (async, active-low)
//   req_valid_i/req_ready_o/req_write_i/req_addr_i/req_wdata_i : access request
//   rsp_valid_o/rsp_ready_i/rsp_rdata_o/rsp_error_o             : response (error = address out of range)
module y86_mem_responder
    import y86_mem_responder_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  req_valid_i,
    output logic  req_ready_o,
    input  logic  req_write_i,
    input  addr_t req_addr_i,
    input  data_t req_wdata_i,
    output logic  rsp_valid_o,
    input  logic  rsp_ready_i,
    output data_t rsp_rdata_o,
    output logic  rsp_error_o
);
    localparam int AW = $clog2(DEPTH_BYTES);
    localparam cnt_t WAIT_INIT = cnt_t'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
    state_t state, state_nx;
    cnt_t cnt;
    logic wr_q, err_q, accept, enter_resp, op_wr, op_err, mem_we;
    addr_t addr_q, op_addr;
    data_t wdata_q, rdata_q, op_wdata, mem_rdata;
    // In IDLE the live request drives the memory so a zero-wait access commits at acceptance.
    always_comb begin
        req_ready_o = state == IDLE;
        accept = req_valid_i && req_ready_o;
        op_wr = req_ready_o ? req_write_i : wr_q;
        op_addr = req_ready_o ? req_addr_i : addr_q;
        op_wdata = req_ready_o ? req_wdata_i : wdata_q;
        op_err = out_of_range(op_addr, addr_t'(DEPTH_BYTES));
        enter_resp = (state == WAIT && cnt == '0) || (WAIT_CYCLES == 0 && accept);
        mem_we = enter_resp && op_wr && !op_err;
        state_nx = accept ? (WAIT_CYCLES == 0 ? RESP : WAIT) :
                   enter_resp ? RESP :
                   (state == RESP && rsp_ready_i) ? IDLE : state;
    end
    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) begin
            state <= IDLE;
            cnt <= '0;
            wr_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                wr_q <= req_write_i;
                addr_q <= req_addr_i;
                wdata_q <= req_wdata_i;
                cnt <= WAIT_INIT;
            end else if (state == WAIT && cnt != '0)
                cnt <= cnt - cnt_t'(1);
            if (enter_resp) begin
                rdata_q <= (op_wr || op_err) ? '0 : mem_rdata;
                err_q <= op_err;
            end
        end
    assign rsp_valid_o = state == RESP;
    assign rsp_rdata_o = rdata_q;
    assign rsp_error_o = err_q;
    mem_byte_array #(.DEPTH_BYTES(DEPTH_BYTES)) u_mem (
        .clk_i (clk_i),
        .addr  (op_addr[AW-1:0]),
        .we    (mem_we),
        .wdata (op_wdata),
        .rdata (mem_rdata)
    );
endmodule
